fast_memory_162: RTL and testbench



---
 rtl/fast_memory_162.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_fast_memory_162.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fast_memory_162.sv
// ---------------------------------------------------------------------------
// fast_memory_162 : Type 162 fast memory, 16 words x 36 bits of flip-flop
// storage shared by four PDP-6 memory-bus ports (p0 highest priority).
//
// Bit 0 is the MSB of every bus word. Only requests flagged with
// fmc_select are answered; everything else belongs to core memory. Every
// output is 0 unless this block is actively responding on that port, so the
// outputs can be wire-ORed onto the shared bus.
//
// Ports:
//   clk, reset (async, active-low), power, sw_single_step, sw_restart
//   per port N = 0..3:
//     in : membus_rq_cyc_pN, membus_rd_rq_pN, membus_wr_rq_pN,
//          membus_ma_pN[21:35] (only [32:35] decoded), membus_sel_pN[18:21]
//          (ignored), membus_fmc_select_pN, membus_mb_in_pN[0:35],
//          membus_wr_rs_pN
//     out: membus_mb_out_pN[0:35], membus_addr_ack_pN, membus_rd_rs_pN
//
// Optional build macro: FASTMEM_CLEAR_ON_RESET_EN
//   defined   -> reset also clears all 16 words
//   undefined -> storage survives reset (bench preloads are kept)
// ---------------------------------------------------------------------------
module fast_memory_162 #(
   parameter logic [3:0] PORT_EN = 4'b1111
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         power,
   input  logic         sw_single_step,
   input  logic         sw_restart,
   // port 0
   input  logic         membus_rq_cyc_p0,
   input  logic         membus_rd_rq_p0,
   input  logic         membus_wr_rq_p0,
   input  logic [21:35] membus_ma_p0,
   input  logic [18:21] membus_sel_p0,
   input  logic         membus_fmc_select_p0,
   input  logic [0:35]  membus_mb_in_p0,
   input  logic         membus_wr_rs_p0,
   output logic [0:35]  membus_mb_out_p0,
   output logic         membus_addr_ack_p0,
   output logic         membus_rd_rs_p0,
   // port 1
   input  logic         membus_rq_cyc_p1,
   input  logic         membus_rd_rq_p1,
   input  logic         membus_wr_rq_p1,
   input  logic [21:35] membus_ma_p1,
   input  logic [18:21] membus_sel_p1,
   input  logic         membus_fmc_select_p1,
   input  logic [0:35]  membus_mb_in_p1,
   input  logic         membus_wr_rs_p1,
   output logic [0:35]  membus_mb_out_p1,
   output logic         membus_addr_ack_p1,
   output logic         membus_rd_rs_p1,
   // port 2
   input  logic         membus_rq_cyc_p2,
   input  logic         membus_rd_rq_p2,
   input  logic         membus_wr_rq_p2,
   input  logic [21:35] membus_ma_p2,
   input  logic [18:21] membus_sel_p2,
   input  logic         membus_fmc_select_p2,
   input  logic [0:35]  membus_mb_in_p2,
   input  logic         membus_wr_rs_p2,
   output logic [0:35]  membus_mb_out_p2,
   output logic         membus_addr_ack_p2,
   output logic         membus_rd_rs_p2,
   // port 3
   input  logic         membus_rq_cyc_p3,
   input  logic         membus_rd_rq_p3,
   input  logic         membus_wr_rq_p3,
   input  logic [21:35] membus_ma_p3,
   input  logic [18:21] membus_sel_p3,
   input  logic         membus_fmc_select_p3,
   input  logic [0:35]  membus_mb_in_p3,
   input  logic         membus_wr_rs_p3,
   output logic [0:35]  membus_mb_out_p3,
   output logic         membus_addr_ack_p3,
   output logic         membus_rd_rs_p3
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ACK   = 3'd1,
      S_RD    = 3'd2,
      S_WWAIT = 3'd3,
      S_DONE  = 3'd4,
      S_HALT  = 3'd5
   } state_t;

   // Storage; referenced hierarchically by the bench for preloading.
   logic [0:35] ff [0:15];

   // Port bit N of these vectors belongs to bus port pN.
   logic [3:0]  w_rq_cyc;
   logic [3:0]  w_rd_rq;
   logic [3:0]  w_wr_rq;
   logic [3:0]  w_fmc;
   logic [3:0]  w_wr_rs;
   logic [3:0]  w_valid;
   logic [0:3]  w_ma [0:3];
   logic [0:35] w_mb_in [0:3];
   logic        w_unused_bits;

   logic        w_any;
   logic [1:0]  w_sel_port;
   state_t      w_next_state;
   logic        w_latch;
   logic        w_wr_en;
   logic [3:0]  w_ack_next;
   logic [3:0]  w_rd_rs_next;
   logic [0:35] w_mb_next;

   state_t      r_state;
   logic [1:0]  r_port;
   logic [3:0]  r_addr;
   logic        r_rd;
   logic        r_wr;
   logic        r_restart_d;
   logic [3:0]  r_ack;
   logic [3:0]  r_rd_rs;
   logic [0:35] r_mb;

   function automatic logic [3:0] f_onehot(input logic [1:0] port);
      f_onehot = 4'b0001 << port;
   endfunction

   assign w_rq_cyc = {membus_rq_cyc_p3, membus_rq_cyc_p2, membus_rq_cyc_p1, membus_rq_cyc_p0};
   assign w_rd_rq  = {membus_rd_rq_p3, membus_rd_rq_p2, membus_rd_rq_p1, membus_rd_rq_p0};
   assign w_wr_rq  = {membus_wr_rq_p3, membus_wr_rq_p2, membus_wr_rq_p1, membus_wr_rq_p0};
   assign w_fmc    = {membus_fmc_select_p3, membus_fmc_select_p2,
                      membus_fmc_select_p1, membus_fmc_select_p0};
   assign w_wr_rs  = {membus_wr_rs_p3, membus_wr_rs_p2, membus_wr_rs_p1, membus_wr_rs_p0};

   assign w_ma[0] = membus_ma_p0[32:35];
   assign w_ma[1] = membus_ma_p1[32:35];
   assign w_ma[2] = membus_ma_p2[32:35];
   assign w_ma[3] = membus_ma_p3[32:35];

   assign w_mb_in[0] = membus_mb_in_p0;
   assign w_mb_in[1] = membus_mb_in_p1;
   assign w_mb_in[2] = membus_mb_in_p2;
   assign w_mb_in[3] = membus_mb_in_p3;

   // High address bits and memory select are routed for core memory only.
   assign w_unused_bits = ^{membus_ma_p0[21:31], membus_ma_p1[21:31],
                            membus_ma_p2[21:31], membus_ma_p3[21:31],
                            membus_sel_p0, membus_sel_p1, membus_sel_p2, membus_sel_p3};

   assign w_valid = w_rq_cyc & w_fmc & (w_rd_rq | w_wr_rq) & PORT_EN & {4{power}};
   assign w_any   = (w_valid != 4'b0000);

   // Fixed-priority port select, p0 wins.
   always_comb begin
      w_sel_port = 2'd0;
      if (w_valid[0]) begin
         w_sel_port = 2'd0;
      end else if (w_valid[1]) begin
         w_sel_port = 2'd1;
      end else if (w_valid[2]) begin
         w_sel_port = 2'd2;
      end else if (w_valid[3]) begin
         w_sel_port = 2'd3;
      end else begin
         w_sel_port = 2'd0;
      end
   end

   // Next-state logic plus the values the output registers take on the next edge.
   always_comb begin
      w_next_state = r_state;
      w_latch      = 1'b0;
      w_wr_en      = 1'b0;
      w_ack_next   = 4'b0000;
      w_rd_rs_next = 4'b0000;
      w_mb_next    = 36'b0;
      if (!power) begin
         w_next_state = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  w_next_state = S_ACK;
                  w_latch      = 1'b1;
                  w_ack_next   = f_onehot(w_sel_port);
               end else begin
                  w_next_state = S_IDLE;
               end
            end
            S_ACK: begin
               if (r_rd) begin
                  w_next_state = S_RD;
                  w_rd_rs_next = f_onehot(r_port);
                  w_mb_next    = ff[r_addr];
               end else begin
                  w_next_state = S_WWAIT;
               end
            end
            S_RD: begin
               w_next_state = r_wr ? S_WWAIT : S_DONE;
            end
            S_WWAIT: begin
               // Loss of rq_cyc means the master gave up: finish without writing.
               if (!w_rq_cyc[r_port]) begin
                  w_next_state = S_DONE;
               end else if (w_wr_rs[r_port]) begin
                  w_wr_en      = 1'b1;
                  w_next_state = S_DONE;
               end else begin
                  w_next_state = S_WWAIT;
               end
            end
            S_DONE: begin
               if (!w_rq_cyc[r_port]) begin
                  w_next_state = sw_single_step ? S_HALT : S_IDLE;
               end else begin
                  w_next_state = S_DONE;
               end
            end
            S_HALT: begin
               if (sw_restart && !r_restart_d) begin
                  w_next_state = S_IDLE;
               end else begin
                  w_next_state = S_HALT;
               end
            end
            default: begin
               w_next_state = S_IDLE;
            end
         endcase
      end
   end

   // State, latched request and registered bus outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_port      <= 2'd0;
         r_addr      <= 4'd0;
         r_rd        <= 1'b0;
         r_wr        <= 1'b0;
         r_restart_d <= 1'b0;
         r_ack       <= 4'b0000;
         r_rd_rs     <= 4'b0000;
         r_mb        <= 36'b0;
      end else begin
         r_state     <= w_next_state;
         r_restart_d <= sw_restart;
         r_ack       <= w_ack_next;
         r_rd_rs     <= w_rd_rs_next;
         r_mb        <= w_mb_next;
         if (w_latch) begin
            r_port <= w_sel_port;
            r_addr <= w_ma[w_sel_port];
            r_rd   <= w_rd_rq[w_sel_port];
            r_wr   <= w_wr_rq[w_sel_port];
         end
      end
   end

`ifdef FASTMEM_CLEAR_ON_RESET_EN
   // Storage write; reset wipes every word.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 16; i++) begin
            ff[i] <= 36'b0;
         end
      end else if (w_wr_en) begin
         ff[r_addr] <= w_mb_in[r_port];
      end
   end
`else
   // Storage write; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         ff[r_addr] <= w_mb_in[r_port];
      end
   end
`endif

   // power gates the registered outputs so the bus goes quiet immediately.
   assign membus_addr_ack_p0 = r_ack[0] & power;
   assign membus_addr_ack_p1 = r_ack[1] & power;
   assign membus_addr_ack_p2 = r_ack[2] & power;
   assign membus_addr_ack_p3 = r_ack[3] & power;

   assign membus_rd_rs_p0 = r_rd_rs[0] & power;
   assign membus_rd_rs_p1 = r_rd_rs[1] & power;
   assign membus_rd_rs_p2 = r_rd_rs[2] & power;
   assign membus_rd_rs_p3 = r_rd_rs[3] & power;

   assign membus_mb_out_p0 = r_mb & {36{r_rd_rs[0] & power}};
   assign membus_mb_out_p1 = r_mb & {36{r_rd_rs[1] & power}};
   assign membus_mb_out_p2 = r_mb & {36{r_rd_rs[2] & power}};
   assign membus_mb_out_p3 = r_mb & {36{r_rd_rs[3] & power}};

endmodule

// File: tb/tb_fast_memory_162.sv
// ---------------------------------------------------------------------------
// tb_fast_memory_162 : scoreboard bench for fast_memory_162.
// Bus-master tasks push the expected addr_ack / rd_rs events (with cycle and
// data) into a queue; a negedge monitor pops and compares whatever the DUT
// presents on each port.
// ---------------------------------------------------------------------------
module tb_fast_memory_162;

   typedef struct {
      int          port;
      bit          is_rd;
      int          cyc;
      logic [0:35] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        power;
   logic        sw_single_step;
   logic        sw_restart;
   logic [3:0]  rq_cyc, rd_rq, wr_rq, fmc, wr_rs;
   logic [21:35] ma [4];
   logic [18:21] sel [4];
   logic [0:35] mb_in [4];
   logic [0:35] mb_out [4];
   logic [3:0]  ack, rd_rs;

   int   cyc = 0;
   int   n_vec = 0;
   int   n_fail = 0;
   exp_t sbq [$];
   int   mon_idx;
   exp_t mon_e;

   fast_memory_162 dut (
      .clk(clk), .reset(reset), .power(power),
      .sw_single_step(sw_single_step), .sw_restart(sw_restart),
      .membus_rq_cyc_p0(rq_cyc[0]), .membus_rd_rq_p0(rd_rq[0]), .membus_wr_rq_p0(wr_rq[0]),
      .membus_ma_p0(ma[0]), .membus_sel_p0(sel[0]), .membus_fmc_select_p0(fmc[0]),
      .membus_mb_in_p0(mb_in[0]), .membus_wr_rs_p0(wr_rs[0]), .membus_mb_out_p0(mb_out[0]),
      .membus_addr_ack_p0(ack[0]), .membus_rd_rs_p0(rd_rs[0]),
      .membus_rq_cyc_p1(rq_cyc[1]), .membus_rd_rq_p1(rd_rq[1]), .membus_wr_rq_p1(wr_rq[1]),
      .membus_ma_p1(ma[1]), .membus_sel_p1(sel[1]), .membus_fmc_select_p1(fmc[1]),
      .membus_mb_in_p1(mb_in[1]), .membus_wr_rs_p1(wr_rs[1]), .membus_mb_out_p1(mb_out[1]),
      .membus_addr_ack_p1(ack[1]), .membus_rd_rs_p1(rd_rs[1]),
      .membus_rq_cyc_p2(rq_cyc[2]), .membus_rd_rq_p2(rd_rq[2]), .membus_wr_rq_p2(wr_rq[2]),
      .membus_ma_p2(ma[2]), .membus_sel_p2(sel[2]), .membus_fmc_select_p2(fmc[2]),
      .membus_mb_in_p2(mb_in[2]), .membus_wr_rs_p2(wr_rs[2]), .membus_mb_out_p2(mb_out[2]),
      .membus_addr_ack_p2(ack[2]), .membus_rd_rs_p2(rd_rs[2]),
      .membus_rq_cyc_p3(rq_cyc[3]), .membus_rd_rq_p3(rd_rq[3]), .membus_wr_rq_p3(wr_rq[3]),
      .membus_ma_p3(ma[3]), .membus_sel_p3(sel[3]), .membus_fmc_select_p3(fmc[3]),
      .membus_mb_in_p3(mb_in[3]), .membus_wr_rs_p3(wr_rs[3]), .membus_mb_out_p3(mb_out[3]),
      .membus_addr_ack_p3(ack[3]), .membus_rd_rs_p3(rd_rs[3])
   );

   always #5 clk = ~clk;

   // Cycle number: bumps on every rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int find_port(input int p);
      find_port = -1;
      for (int i = 0; i < sbq.size(); i++) begin
         if (sbq[i].port == p) begin
            find_port = i;
            break;
         end
      end
   endfunction

   // Monitor: every bus output event is matched against the scoreboard.
   always @(negedge clk) begin
      for (int p = 0; p < 4; p++) begin
         if (ack[p]) begin
            n_vec++;
            mon_idx = find_port(p);
            if (mon_idx < 0) begin
               n_fail++;
               $display("FAIL unexpected_ack p%0d: got addr_ack at cycle %0d, required none", p, cyc);
            end else begin
               mon_e = sbq[mon_idx];
               sbq.delete(mon_idx);
               if (mon_e.is_rd || mon_e.cyc != cyc) begin
                  n_fail++;
                  $display("FAIL ack p%0d: got addr_ack at cycle %0d, required %s at cycle %0d",
                           p, cyc, mon_e.is_rd ? "rd_rs" : "addr_ack", mon_e.cyc);
               end
            end
         end
         if (rd_rs[p]) begin
            n_vec++;
            mon_idx = find_port(p);
            if (mon_idx < 0) begin
               n_fail++;
               $display("FAIL unexpected_rd_rs p%0d: got rd_rs at cycle %0d data %o, required none",
                        p, cyc, mb_out[p]);
            end else begin
               mon_e = sbq[mon_idx];
               sbq.delete(mon_idx);
               if (!mon_e.is_rd || mon_e.cyc != cyc || mb_out[p] !== mon_e.data) begin
                  n_fail++;
                  $display("FAIL rd p%0d: got rd_rs cycle %0d data %o, required %s cycle %0d data %o",
                           p, cyc, mb_out[p], mon_e.is_rd ? "rd_rs" : "addr_ack", mon_e.cyc, mon_e.data);
               end
            end
         end else begin
            n_vec++;
            if (mb_out[p] !== 36'b0) begin
               n_fail++;
               $display("FAIL idle_mb_out p%0d: got %o at cycle %0d, required 0", p, mb_out[p], cyc);
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drop(input int p);
      rq_cyc[p] = 1'b0; rd_rq[p] = 1'b0; wr_rq[p] = 1'b0;
      fmc[p] = 1'b0; wr_rs[p] = 1'b0; mb_in[p] = 36'b0;
   endtask

   // Bus master: call just after a rising edge; dly = cycles from issue to addr_ack.
   task automatic master(input int p, input bit rd, input bit wr, input logic [3:0] a,
                         input logic [0:35] wdata, input int dly, input logic [0:35] rdata);
      exp_t e;
      bit   got;
      e.port = p; e.is_rd = 1'b0; e.cyc = cyc + dly; e.data = 36'b0;
      sbq.push_back(e);
      if (rd) begin
         e.is_rd = 1'b1; e.cyc = cyc + dly + 1; e.data = rdata;
         sbq.push_back(e);
      end
      ma[p] = {11'h5A5, a};
      fmc[p] = 1'b1; rd_rq[p] = rd; wr_rq[p] = wr; rq_cyc[p] = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = ack[p];
      end
      if (!got) begin
         n_vec++; n_fail++;
         $display("FAIL ack_timeout p%0d: got no addr_ack, required addr_ack", p);
      end else begin
         if (rd) begin
            got = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin
               @(negedge clk);
               got = rd_rs[p];
            end
            if (!got) begin
               n_vec++; n_fail++;
               $display("FAIL rd_timeout p%0d: got no rd_rs, required rd_rs", p);
            end
         end
         if (wr) begin
            @(posedge clk); #1;
            mb_in[p] = wdata; wr_rs[p] = 1'b1;
         end
      end
      @(posedge clk); #1;
      drop(p);
   endtask

   // Start a write, then kill it in WWAIT with reset or power loss.
   task automatic abort_wr(input int p, input logic [3:0] a, input bit by_reset);
      exp_t e;
      e.port = p; e.is_rd = 1'b0; e.cyc = cyc + 1; e.data = 36'b0;
      sbq.push_back(e);
      ma[p] = {11'h5A5, a};
      fmc[p] = 1'b1; wr_rq[p] = 1'b1; rq_cyc[p] = 1'b1;
      idle(2);
      mb_in[p] = 36'o777777777777; wr_rs[p] = 1'b1;
      if (by_reset) reset = 1'b0; else power = 1'b0;
      @(negedge clk);
      n_vec++;
      if (ack !== 4'b0 || rd_rs !== 4'b0 || mb_out[p] !== 36'b0) begin
         n_fail++;
         $display("FAIL abort_outputs: got ack=%b rd_rs=%b mb=%o, required all 0", ack, rd_rs, mb_out[p]);
      end
      idle(2);
      drop(p);
      reset = 1'b1; power = 1'b1;
      idle(2);
   endtask

   task automatic chk_ff(input int a, input logic [0:35] want, input string name);
      n_vec++;
      if (dut.ff[a] !== want) begin
         n_fail++;
         $display("FAIL %s: ff[%0d] got %o, required %o", name, a, dut.ff[a], want);
      end
   endtask

   task automatic preload();
      for (int i = 0; i < 16; i++) dut.ff[i] <= 36'b0;
      dut.ff[3]  <= 36'o777777666666;
      dut.ff[4]  <= 36'o000111222333;
      dut.ff[7]  <= 36'o543210765432;
      dut.ff[9]  <= 36'o700000000007;
      dut.ff[10] <= 36'o010101010101;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no end of test, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; power = 1'b1; sw_single_step = 1'b0; sw_restart = 1'b0;
      rq_cyc = 4'b0; rd_rq = 4'b0; wr_rq = 4'b0; fmc = 4'b0; wr_rs = 4'b0;
      for (int p = 0; p < 4; p++) begin
         ma[p] = 15'b0; mb_in[p] = 36'b0; sel[p] = 4'b1010;
      end
`ifndef FASTMEM_CLEAR_ON_RESET_EN
      preload();
`endif
      idle(3);
      n_vec++;
      if (ack !== 4'b0 || rd_rs !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got ack=%b rd_rs=%b, required 0", ack, rd_rs);
      end
      reset = 1'b1;
`ifdef FASTMEM_CLEAR_ON_RESET_EN
      preload();
`endif
      idle(2);

      // single read, word 3
      master(0, 1'b1, 1'b0, 4'd3, 36'b0, 1, 36'o777777666666);
      idle(2);
      // write word 5, then read it back
      master(0, 1'b0, 1'b1, 4'd5, 36'o112233445566, 1, 36'b0);
      idle(2);
      master(0, 1'b1, 1'b0, 4'd5, 36'b0, 1, 36'o112233445566);
      idle(2);

      // request without fmc_select belongs to core memory
      ma[2] = 15'o123; rd_rq[2] = 1'b1; wr_rq[2] = 1'b1; rq_cyc[2] = 1'b1; fmc[2] = 1'b0;
      mb_in[2] = 36'o555555555555; wr_rs[2] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_vec++;
         if (ack !== 4'b0 || rd_rs !== 4'b0) begin
            n_fail++;
            $display("FAIL no_fmc: got ack=%b rd_rs=%b, required 0", ack, rd_rs);
         end
      end
      @(posedge clk); #1;
      drop(2);
      idle(2);
      chk_ff(3, 36'o777777666666, "no_fmc_word");

      // p0 and p1 collide; p1 acked only after p0 drops rq_cyc
      fork
         master(0, 1'b1, 1'b0, 4'd3, 36'b0, 1, 36'o777777666666);
         master(1, 1'b1, 1'b0, 4'd4, 36'b0, 5, 36'o000111222333);
      join
      idle(2);

      // read-modify-write on word 7 from p3, then read back
      master(3, 1'b1, 1'b1, 4'd7, 36'o1, 1, 36'o543210765432);
      idle(2);
      master(3, 1'b1, 1'b0, 4'd7, 36'b0, 1, 36'o1);
      idle(2);

      // single step: second request waits for a sw_restart rising edge
      sw_single_step = 1'b1;
      master(2, 1'b1, 1'b0, 4'd3, 36'b0, 1, 36'o777777666666);
      idle(1);
      fork
         master(2, 1'b1, 1'b0, 4'd4, 36'b0, 6, 36'o000111222333);
         begin
            idle(4);
            sw_restart = 1'b1;
            idle(1);
            sw_restart = 1'b0;
         end
      join
      sw_single_step = 1'b0;
      idle(1);
      sw_restart = 1'b1;
      idle(1);
      sw_restart = 1'b0;
      idle(2);

      chk_ff(5, 36'o112233445566, "write_word5");
      chk_ff(7, 36'o1, "rmw_word7");

      // power loss in WWAIT: no write
      abort_wr(0, 4'd10, 1'b0);
      chk_ff(10, 36'o010101010101, "power_abort_word10");
      master(0, 1'b1, 1'b0, 4'd10, 36'b0, 1, 36'o010101010101);
      idle(2);

      // reset in WWAIT: no write
      abort_wr(1, 4'd9, 1'b1);
`ifdef FASTMEM_CLEAR_ON_RESET_EN
      chk_ff(9, 36'b0, "reset_abort_word9");
`else
      chk_ff(9, 36'o700000000007, "reset_abort_word9");
      chk_ff(3, 36'o777777666666, "reset_keeps_word3");
`endif

      idle(3);
      n_vec++;
      if (sbq.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending events, required 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
